opacc_ctrl: RTL and testbench
=============================

// Module: opacc_ctrl
// PURPOSE
//  Sequencer for the MPU outer-product accumulator datapath (ml x vl tile of XLEN accumulators).
//  Runs one tile job per accepted command: LOAD (shift in ml C rows), MAC (K a/b outer-product
//  beats), DRAIN (shift out ml result rows). Sits between the MPU issue/stream logic and the
//  datapath's ab_valid/c_valid/vi_*/vo_c pins. Guarantees the two datapath strobes never coincide.
// PARAMETERS
//  vl    4   columns per C row / elements of b
//  ml    4   rows of C / elements of a
//  XLEN  64  element width
//  KW    16  width of the cmd_k beat count
// PORTS
//  clk          in   1         clock
//  reset        in   1         synchronous active-high reset
//  cmd_valid    in   1         job request
//  cmd_ready    out  1         high only in IDLE
//  cmd_k        in   KW        number of a/b beats; 0 legal (no MAC)
//  cmd_load_c   in   1         1: take C rows from c_in stream; 0: load zero rows
//  c_in_valid   in   1         C row beat valid
//  c_in_ready   out  1         high only in LOAD with latched load_c=1
//  c_in_data    in   vl*XLEN   C row
//  ab_in_valid  in   1         a/b beat valid
//  ab_in_ready  out  1         high only in MAC
//  a_in         in   ml*XLEN   a vector
//  b_in         in   vl*XLEN   b vector
//  c_out_valid  out  1         result row valid (DRAIN)
//  c_out_ready  in   1         result row accepted
//  c_out_data   out  vl*XLEN   result row (= dp_vo_c)
//  c_out_last   out  1         high on the ml-th result row
//  dp_ab_valid  out  1         to datapath ab_valid
//  dp_c_valid   out  1         to datapath c_valid
//  dp_vi_a      out  ml*XLEN   to datapath vi_a (= a_in)
//  dp_vi_b      out  vl*XLEN   to datapath vi_b (= b_in)
//  dp_vi_c      out  vl*XLEN   to datapath vi_c
//  dp_vo_c      in   vl*XLEN   from datapath vo_c (deepest row)
//  busy         out  1         state != IDLE
//  perf_busy    out  32        busy-cycle count (see CONFIGURATION)
//  perf_mac     out  32        accepted a/b beat count
//  perf_stall   out  32        MAC-state cycles without ab_in_valid
// BEHAVIOUR
//  - Reset (sync, same reset as datapath): state=IDLE, counters=0, all valid/ready outs 0
//    except cmd_ready=1; perf counters=0. Reset mid-job aborts; no partial output beats.
//  - All ready outputs are functions of registered state only (no valid->ready comb paths).
//  - IDLE: cmd_valid&&cmd_ready latches cmd_k, cmd_load_c; row_cnt=0 -> LOAD next cycle.
//  - LOAD: a row beat is c_in_valid&&c_in_ready (load_c=1) or every cycle (load_c=0).
//    Per beat dp_c_valid=1, dp_vi_c=c_in_data (or 0); row_cnt++. After ml-th beat:
//    -> MAC if k!=0, else -> DRAIN. First row loaded is first row drained.
//  - MAC: dp_ab_valid=ab_in_valid&&ab_in_ready; k_cnt++ per beat; after k-th beat -> DRAIN.
//    Datapath adds a[i]*b[j] into C[i][j], truncated to XLEN (modulo 2^XLEN).
//  - DRAIN: c_out_valid=1, c_out_data=dp_vo_c; on c_out_valid&&c_out_ready: dp_c_valid=1,
//    dp_vi_c=0 (shift next row up); c_out_last when row_cnt==ml-1. After ml-th -> IDLE.
//    c_out_valid held, data stable while c_out_ready=0.
//  - dp_c_valid and dp_ab_valid mutually exclusive; both 0 in IDLE. dp_vi_c=0 outside LOAD.
//  - Min job latency (k=K, no stalls): 1 (accept) + ml + K + ml cycles; >=1 IDLE cycle
//    between jobs. cmd_k=2^KW-1 legal; k_cnt must not wrap before match.
// CONFIGURATION
//  OPACC_CTRL_PERF_EN defined: perf_busy +1 each busy cycle, perf_mac +1 per a/b beat,
//    perf_stall +1 per MAC cycle with ab_in_valid=0; all saturate at 2^32-1, clear on reset.
//  Not defined: perf_* tied to 0, no counter flops; ports still present.
// TESTING (ml=vl=4, XLEN=64, KW=16)
//  1. cmd k=1 load_c=0; a={1,2,3,4}, b={1,1,1,1} -> rows {1,1,1,1},{2,2,2,2},{3,..},{4,..}, last on row 4.
//  2. cmd k=0 load_c=1, C rows 10,20,30,40 (all lanes) -> same rows drained in order, no dp_ab_valid.
//  3. k=3, ab_in_valid toggled 1,0,0,1,1 -> exactly 3 dp_ab_valid pulses; PERF_EN: perf_stall=2, perf_mac=3.
//  4. DRAIN with c_out_ready low 5 cycles on row 2 -> c_out_data stable, no dp_c_valid during stall.
//  5. load_c=1, a=b=all 2^63 lanes, k=1 -> C+0 (2^126 truncates to 0 mod 2^64); row values = loaded C.
//  6. reset asserted mid-MAC -> next cycle IDLE, cmd_ready=1, no c_out_valid; new job correct.

Source files
------------

// File: rtl/opacc_ctrl.sv
// opacc_ctrl: sequencer for the ml x vl outer-product accumulator datapath.
// One tile job per command: LOAD ml C rows, MAC K a/b beats, DRAIN ml result rows.
// Optional feature macro: OPACC_CTRL_PERF_EN (saturating perf counters; tied to 0 otherwise).
module opacc_ctrl #(
    parameter int vl   = 4,
    parameter int ml   = 4,
    parameter int XLEN = 64,
    parameter int KW   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [KW-1:0]        cmd_k,
    input  logic                 cmd_load_c,
    input  logic                 c_in_valid,
    output logic                 c_in_ready,
    input  logic [vl*XLEN-1:0]   c_in_data,
    input  logic                 ab_in_valid,
    output logic                 ab_in_ready,
    input  logic [ml*XLEN-1:0]   a_in,
    input  logic [vl*XLEN-1:0]   b_in,
    output logic                 c_out_valid,
    input  logic                 c_out_ready,
    output logic [vl*XLEN-1:0]   c_out_data,
    output logic                 c_out_last,
    output logic                 dp_ab_valid,
    output logic                 dp_c_valid,
    output logic [ml*XLEN-1:0]   dp_vi_a,
    output logic [vl*XLEN-1:0]   dp_vi_b,
    output logic [vl*XLEN-1:0]   dp_vi_c,
    input  logic [vl*XLEN-1:0]   dp_vo_c,
    output logic                 busy,
    output logic [31:0]          perf_busy,
    output logic [31:0]          perf_mac,
    output logic [31:0]          perf_stall
);

    localparam int RW = (ml > 1) ? $clog2(ml) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, MAC, DRAIN} state_t;

    state_t          state, state_nx;
    logic [KW-1:0]   k_reg, k_cnt;
    logic            load_c;
    logic [RW-1:0]   row_cnt;
    logic            row_last, k_last;
    logic            c_beat, ab_beat, out_beat;

    // Operand vectors and result row pass straight through.
    assign dp_vi_a    = a_in;
    assign dp_vi_b    = b_in;
    assign c_out_data = dp_vo_c;

    // Next state and strobes; readies decode from registered state only.
    always_comb begin
        state_nx    = state;
        cmd_ready   = (state == IDLE);
        busy        = (state != IDLE);
        c_in_ready  = (state == LOAD) && load_c;
        ab_in_ready = (state == MAC);
        c_out_valid = (state == DRAIN);
        row_last    = (row_cnt == RW'(ml - 1));
        // k_reg >= 1 whenever MAC is entered, so k_reg-1 never underflows there.
        k_last      = (k_cnt == k_reg - KW'(1));
        c_beat      = (state == LOAD) && (load_c ? c_in_valid : 1'b1);
        ab_beat     = (state == MAC) && ab_in_valid;
        out_beat    = (state == DRAIN) && c_out_ready;
        // Beats are state-exclusive, so the two datapath strobes never coincide.
        dp_c_valid  = c_beat || out_beat;
        dp_ab_valid = ab_beat;
        dp_vi_c     = ((state == LOAD) && load_c) ? c_in_data : '0;
        c_out_last  = (state == DRAIN) && row_last;
        case (state)
            IDLE:    if (cmd_valid) state_nx = LOAD;
            LOAD:    if (c_beat && row_last) state_nx = (k_reg != '0) ? MAC : DRAIN;
            MAC:     if (ab_beat && k_last) state_nx = DRAIN;
            DRAIN:   if (out_beat && row_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register plus job/row/beat counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            k_reg   <= '0;
            k_cnt   <= '0;
            load_c  <= 1'b0;
            row_cnt <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (cmd_valid) begin
                    k_reg   <= cmd_k;
                    load_c  <= cmd_load_c;
                    k_cnt   <= '0;
                    row_cnt <= '0;
                end
                LOAD:  if (c_beat) row_cnt <= row_last ? '0 : row_cnt + RW'(1);
                MAC:   if (ab_beat) k_cnt <= k_cnt + KW'(1);
                DRAIN: if (out_beat) row_cnt <= row_last ? '0 : row_cnt + RW'(1);
                default: ;
            endcase
        end
    end

`ifdef OPACC_CTRL_PERF_EN
    logic [31:0] pb_q, pm_q, ps_q;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            pb_q <= '0;
            pm_q <= '0;
            ps_q <= '0;
        end else begin
            if (busy && pb_q != '1) pb_q <= pb_q + 32'd1;
            if (ab_beat && pm_q != '1) pm_q <= pm_q + 32'd1;
            if ((state == MAC) && !ab_in_valid && ps_q != '1) ps_q <= ps_q + 32'd1;
        end
    end

    assign perf_busy  = pb_q;
    assign perf_mac   = pm_q;
    assign perf_stall = ps_q;
`else
    assign perf_busy  = '0;
    assign perf_mac   = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_opacc_ctrl.sv
// tb_opacc_ctrl: directed + randomized jobs against a tile-level arithmetic model.
// The bench hosts a simple shift/accumulate datapath so drained rows can be checked.
module tb_opacc_ctrl;
    localparam int ML = 4, VL = 4, XLEN = 64, KW = 16;
    localparam int W  = VL * XLEN;
    typedef logic [W-1:0] vec_t;

    logic            clk = 0, reset = 1;
    logic            cmd_valid = 0, cmd_ready, cmd_load_c = 0;
    logic [KW-1:0]   cmd_k = '0;
    logic            c_in_valid = 0, c_in_ready;
    vec_t            c_in_data = '0;
    logic            ab_in_valid = 0, ab_in_ready;
    logic [ML*XLEN-1:0] a_in = '0;
    vec_t            b_in = '0;
    logic            c_out_valid, c_out_ready = 0, c_out_last;
    vec_t            c_out_data;
    logic            dp_ab_valid, dp_c_valid;
    logic [ML*XLEN-1:0] dp_vi_a;
    vec_t            dp_vi_b, dp_vi_c, dp_vo_c;
    logic            busy;
    logic [31:0]     perf_busy, perf_mac, perf_stall;

    opacc_ctrl #(.vl(VL), .ml(ML), .XLEN(XLEN), .KW(KW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k), .cmd_load_c(cmd_load_c),
        .c_in_valid(c_in_valid), .c_in_ready(c_in_ready), .c_in_data(c_in_data),
        .ab_in_valid(ab_in_valid), .ab_in_ready(ab_in_ready), .a_in(a_in), .b_in(b_in),
        .c_out_valid(c_out_valid), .c_out_ready(c_out_ready), .c_out_data(c_out_data),
        .c_out_last(c_out_last), .dp_ab_valid(dp_ab_valid), .dp_c_valid(dp_c_valid),
        .dp_vi_a(dp_vi_a), .dp_vi_b(dp_vi_b), .dp_vi_c(dp_vi_c), .dp_vo_c(dp_vo_c),
        .busy(busy), .perf_busy(perf_busy), .perf_mac(perf_mac), .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: rows shift in at acc[0], deepest row acc[ML-1] drives vo_c.
    vec_t acc [ML];
    assign dp_vo_c = acc[ML-1];
    always @(posedge clk) begin
        if (dp_c_valid) begin
            for (int p = ML - 1; p > 0; p--) acc[p] <= acc[p-1];
            acc[0] <= dp_vi_c;
        end else if (dp_ab_valid) begin
            for (int p = 0; p < ML; p++)
                for (int j = 0; j < VL; j++)
                    acc[p][j*XLEN +: XLEN] <= acc[p][j*XLEN +: XLEN] +
                        dp_vi_a[(ML-1-p)*XLEN +: XLEN] * dp_vi_b[j*XLEN +: XLEN];
        end
    end

    int n_chk = 0, n_pass = 0;
    int exp_busy = 0, exp_mac = 0, exp_stall = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Strobes must never coincide, checked every cycle away from the edge.
    always @(negedge clk) begin
        #2;
        chk("strobe_excl", W'(dp_c_valid & dp_ab_valid), '0);
    end

    // Job description filled before each run.
    vec_t               c_rows [ML];
    logic [ML*XLEN-1:0] a_q [$];
    vec_t               b_q [$];
    int                 ab_gap [$];
    int                 in_gap [ML];
    int                 out_stall [ML];

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int i = 0; i < VL; i++) v[i*XLEN +: XLEN] = {$urandom(), $urandom()};
        return v;
    endfunction

    task automatic gen_job(input int k, input int maxgap);
        a_q.delete(); b_q.delete(); ab_gap.delete();
        for (int r = 0; r < ML; r++) begin
            c_rows[r]    = rnd_vec();
            in_gap[r]    = $urandom_range(0, maxgap);
            out_stall[r] = $urandom_range(0, maxgap);
        end
        for (int b = 0; b < k; b++) begin
            a_q.push_back(rnd_vec());
            b_q.push_back(rnd_vec());
            ab_gap.push_back($urandom_range(0, maxgap));
        end
    endtask

    // One cycle: move to the falling edge, drop all handshake inputs.
    task automatic tick();
        @(negedge clk);
        cmd_valid = 0; c_in_valid = 0; ab_in_valid = 0; c_out_ready = 0;
    endtask

    task automatic chk_perf();
`ifdef OPACC_CTRL_PERF_EN
        chk("perf_busy", W'(perf_busy), W'(exp_busy));
        chk("perf_mac", W'(perf_mac), W'(exp_mac));
        chk("perf_stall", W'(perf_stall), W'(exp_stall));
`else
        chk("perf_off", W'({perf_busy, perf_mac, perf_stall}), '0);
`endif
    endtask

    task automatic run_job(input int k, input bit load_c);
        vec_t exp_rows [ML];
        logic [XLEN-1:0] s;
        // Tile result: C + sum over beats of a*b^T, each lane modulo 2^XLEN.
        for (int r = 0; r < ML; r++)
            for (int j = 0; j < VL; j++) begin
                s = load_c ? c_rows[r][j*XLEN +: XLEN] : '0;
                for (int b = 0; b < k; b++)
                    s = s + a_q[b][r*XLEN +: XLEN] * b_q[b][j*XLEN +: XLEN];
                exp_rows[r][j*XLEN +: XLEN] = s;
            end
        tick();
        cmd_valid = 1; cmd_k = KW'(k); cmd_load_c = load_c;
        #1 chk("cmd_ready", W'(cmd_ready), 1);
        for (int r = 0; r < ML; r++) begin
            if (load_c) begin
                for (int g = 0; g < in_gap[r]; g++) begin
                    tick(); exp_busy++;
                    #1 chk("load_wait", W'({c_in_ready, dp_c_valid}), W'(2'b10));
                end
                tick(); exp_busy++;
                c_in_valid = 1; c_in_data = c_rows[r];
                #1 chk("load_vi_c", dp_vi_c, c_rows[r]);
                chk("load_cv", W'({c_in_ready, dp_c_valid, cmd_ready}), W'(3'b110));
            end else begin
                tick(); exp_busy++;
                c_in_data = rnd_vec();
                #1 chk("zload_vi_c", dp_vi_c, '0);
                chk("zload_cv", W'({c_in_ready, dp_c_valid}), W'(2'b01));
            end
        end
        for (int b = 0; b < k; b++) begin
            for (int g = 0; g < ab_gap[b]; g++) begin
                tick(); exp_busy++; exp_stall++;
                a_in = rnd_vec(); b_in = rnd_vec();
                #1 chk("mac_wait", W'({ab_in_ready, dp_ab_valid, dp_c_valid}), W'(3'b100));
            end
            tick(); exp_busy++; exp_mac++;
            ab_in_valid = 1; a_in = a_q[b]; b_in = b_q[b];
            #1 chk("mac_beat", W'({ab_in_ready, dp_ab_valid}), W'(2'b11));
            chk("mac_vi_c", dp_vi_c, '0);
        end
        for (int r = 0; r < ML; r++) begin
            for (int g = 0; g < out_stall[r]; g++) begin
                tick(); exp_busy++;
                #1 chk("drain_hold", c_out_data, exp_rows[r]);
                chk("drain_hold_v", W'({c_out_valid, dp_c_valid, dp_ab_valid}), W'(3'b100));
            end
            tick(); exp_busy++;
            c_out_ready = 1;
            #1 chk("drain_data", c_out_data, exp_rows[r]);
            chk("drain_ctl", W'({c_out_valid, c_out_last, dp_c_valid}),
                W'({1'b1, (r == ML - 1), 1'b1}));
            chk("drain_vi_c", dp_vi_c, '0);
        end
        tick();
        #1 chk("job_done", W'({busy, cmd_ready, c_out_valid, ab_in_ready}), W'(4'b0100));
        chk_perf();
    endtask

    initial begin
        repeat (2) tick();
        #1 chk("rst_state", W'({cmd_ready, busy, c_in_ready, ab_in_ready, c_out_valid,
                                dp_c_valid, dp_ab_valid}), W'(7'b1000000));
        chk_perf();
        reset = 0;

        // Test 1: zero C, a={1,2,3,4}, b=all 1 -> rows of 1,2,3,4.
        gen_job(1, 0);
        for (int i = 0; i < ML; i++) a_q[0][i*XLEN +: XLEN] = 64'(i + 1);
        for (int j = 0; j < VL; j++) b_q[0][j*XLEN +: XLEN] = 64'd1;
        run_job(1, 0);

        // Test 2: k=0, C rows 10,20,30,40 pass straight through.
        gen_job(0, 1);
        for (int r = 0; r < ML; r++)
            for (int j = 0; j < VL; j++) c_rows[r][j*XLEN +: XLEN] = 64'(10 * (r + 1));
        run_job(0, 1);

        // Test 3: k=3, ab_in_valid pattern 1,0,0,1,1.
        gen_job(3, 0);
        ab_gap[0] = 0; ab_gap[1] = 2; ab_gap[2] = 0;
        run_job(3, 1);

        // Test 4: consumer stalls 5 cycles on the second result row.
        gen_job(2, 0);
        out_stall[1] = 5;
        run_job(2, 1);

        // Test 5: 2^63 * 2^63 wraps to zero, so C drains unchanged.
        gen_job(1, 1);
        a_q[0] = {VL{64'h8000_0000_0000_0000}};
        b_q[0] = {VL{64'h8000_0000_0000_0000}};
        run_job(1, 1);

        // Randomized jobs.
        for (int n = 0; n < 20; n++) begin
            int k;
            k = $urandom_range(0, 5);
            gen_job(k, 3);
            run_job(k, 1'($urandom_range(0, 1)));
        end

        // Test 6: reset in the middle of MAC aborts the job.
        tick();
        cmd_valid = 1; cmd_k = 16'd4; cmd_load_c = 0;
        repeat (ML) tick();
        tick();
        ab_in_valid = 1; a_in = rnd_vec(); b_in = rnd_vec();
        tick();
        reset = 1;
        tick();
        reset = 0;
        exp_busy = 0; exp_mac = 0; exp_stall = 0;
        #1 chk("abort_state", W'({cmd_ready, busy, c_out_valid, dp_c_valid, ab_in_ready}),
                W'(5'b10000));
        chk_perf();
        tick();
        #1 chk("abort_idle", W'({cmd_ready, c_out_valid}), W'(2'b10));
        gen_job(3, 2);
        run_job(3, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
